// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised FIFO.
// Provides the read-mode enum, a clog2 helper and pointer wrap.
package fifo_pkg;

    typedef enum logic [0:0] {
        MODE_STD  = 1'b0,
        MODE_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Wraps explicitly so that non power-of-two depths work.
    function automatic int next_ptr(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH storage: one synchronous write, one async read.
// Ports: clk, we/waddr/wdata write side, raddr/rdata read side.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with count, thresholds, sticky errors, flush, FWFT.
// Ports: clk, reset_n, clear, wr/data_in, rd/data_out, status flags.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AW        = clog2(DEPTH),
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1,
    parameter int FWFT      = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             wr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rd,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    if (DEPTH < 2 || AFULL_TH < 0 || AFULL_TH > DEPTH ||
        AEMPTY_TH < 0 || AEMPTY_TH >= DEPTH ||
        AW != clog2(DEPTH) || WIDTH < 1) begin : g_bad_param
        $fatal(1, "sync_fifo_param: illegal parameters");
    end

    localparam fifo_mode_e MODE =
        (FWFT != 0) ? MODE_FWFT : MODE_STD;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] AE_C    = (AW+1)'(AEMPTY_TH);
    localparam logic        AF_RST  = (AFULL_TH == 0);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr_nx;
    logic [AW-1:0]    rd_ptr_nx;
    logic [AW:0]      count_nx;
    logic             wr_ok;
    logic             rd_ok;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] dout_q;

    // A read frees a slot, so a full FIFO may accept wr&rd together.
    assign rd_ok = rd & ~empty;
    assign wr_ok = wr & (~full | rd_ok);

    assign wr_ptr_nx = AW'(next_ptr(int'(wr_ptr), DEPTH));
    assign rd_ptr_nx = AW'(next_ptr(int'(rd_ptr), DEPTH));

    always_comb begin
        count_nx = count;
        unique case (1'b1)
            (wr_ok & ~rd_ok): count_nx = count + 1'b1;
            (rd_ok & ~wr_ok): count_nx = count - 1'b1;
            default:          count_nx = count;
        endcase
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok & ~clear),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= AF_RST;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= AF_RST;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr_nx;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr_nx;
            end
            count        <= count_nx;
            empty        <= (count_nx == '0);
            full         <= (count_nx == DEPTH_C);
            almost_empty <= (count_nx <= AE_C);
            almost_full  <= (count_nx >= AF_C);
            if (wr & ~wr_ok) begin
                overflow <= 1'b1;
            end
            if (rd & empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Registered read port; holds its last word between reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_q <= '0;
        end else if (!clear && rd_ok) begin
            dout_q <= rd_data;
        end
    end

    // FWFT shows the head directly; the value is masked while empty.
    assign data_out = (MODE == MODE_FWFT)
                    ? (empty ? '0 : rd_data)
                    : dout_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param.
// Three instances: 8x8 std, depth-5 FWFT, depth-16 thresholds.
module tb_sync_fifo_param;

    logic       clk;
    logic       reset_n;
    logic       wr   [3];
    logic       rd   [3];
    logic       clr  [3];
    logic [7:0] din  [3];
    logic [7:0] dout [3];
    logic       emp  [3];
    logic       ful  [3];
    logic       af   [3];
    logic       ae   [3];
    logic       ovf  [3];
    logic       udf  [3];
    logic [3:0] cnt_a;
    logic [3:0] cnt_b;
    logic [4:0] cnt_c;

    int md  [3] = '{8, 5, 16};
    int maf [3] = '{7, 4, 12};
    int mae [3] = '{1, 1, 3};
    int mfw [3] = '{0, 1, 0};

    logic [7:0] mq  [3][16];
    int         mn  [3];
    int         movf[3];
    int         mudf[3];
    logic [7:0] mdo [3];

    int n_chk;
    int n_pass;

    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .FWFT(0)) u_a (
        .clk(clk), .reset_n(reset_n), .clear(clr[0]),
        .wr(wr[0]), .data_in(din[0]), .rd(rd[0]),
        .data_out(dout[0]), .empty(emp[0]), .full(ful[0]),
        .almost_full(af[0]), .almost_empty(ae[0]),
        .count(cnt_a), .overflow(ovf[0]), .underflow(udf[0])
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(5), .FWFT(1)) u_b (
        .clk(clk), .reset_n(reset_n), .clear(clr[1]),
        .wr(wr[1]), .data_in(din[1]), .rd(rd[1]),
        .data_out(dout[1]), .empty(emp[1]), .full(ful[1]),
        .almost_full(af[1]), .almost_empty(ae[1]),
        .count(cnt_b), .overflow(ovf[1]), .underflow(udf[1])
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AFULL_TH(12),
                      .AEMPTY_TH(3), .FWFT(0)) u_c (
        .clk(clk), .reset_n(reset_n), .clear(clr[2]),
        .wr(wr[2]), .data_in(din[2]), .rd(rd[2]),
        .data_out(dout[2]), .empty(emp[2]), .full(ful[2]),
        .almost_full(af[2]), .almost_empty(ae[2]),
        .count(cnt_c), .overflow(ovf[2]), .underflow(udf[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cnt_of(input int i);
        case (i)
            0:       return int'(cnt_a);
            1:       return int'(cnt_b);
            default: return int'(cnt_c);
        endcase
    endfunction

    task automatic chk(input string tag, input int obs,
                       input int exp);
        n_chk = n_chk + 1;
        if (obs == exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)",
                     tag, obs, obs, exp, exp);
        end
    endtask

    task automatic set(input int i, input logic w, input logic r,
                       input logic [7:0] d, input logic c);
        wr[i]  = w;
        rd[i]  = r;
        din[i] = d;
        clr[i] = c;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) set(i, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mn[i]   = 0;
            movf[i] = 0;
            mudf[i] = 0;
            mdo[i]  = 8'h00;
        end
    endtask

    task automatic model_step();
        bit e, f, rok, wok;
        for (int i = 0; i < 3; i++) begin
            e   = (mn[i] == 0);
            f   = (mn[i] == md[i]);
            rok = rd[i] && !e;
            wok = wr[i] && (!f || rok);
            if (clr[i]) begin
                mn[i]   = 0;
                movf[i] = 0;
                mudf[i] = 0;
            end else begin
                if (rd[i] && e) mudf[i] = 1;
                if (wr[i] && !wok) movf[i] = 1;
                if (rok) begin
                    mdo[i] = mq[i][0];
                    for (int k = 0; k < 15; k++) mq[i][k] = mq[i][k+1];
                    mn[i] = mn[i] - 1;
                end
                if (wok) begin
                    mq[i][mn[i]] = din[i];
                    mn[i] = mn[i] + 1;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d_count", i), cnt_of(i), mn[i]);
            chk($sformatf("u%0d_empty", i), emp[i], mn[i] == 0);
            chk($sformatf("u%0d_full", i), ful[i], mn[i] == md[i]);
            chk($sformatf("u%0d_afull", i), af[i], mn[i] >= maf[i]);
            chk($sformatf("u%0d_aempty", i), ae[i], mn[i] <= mae[i]);
            chk($sformatf("u%0d_ovf", i), ovf[i], movf[i]);
            chk($sformatf("u%0d_udf", i), udf[i], mudf[i]);
            if (mfw[i] == 0)
                chk($sformatf("u%0d_dout", i), dout[i], mdo[i]);
            else if (mn[i] > 0)
                chk($sformatf("u%0d_head", i), dout[i], mq[i][0]);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        reset_n = 1'b0;
        idle_all();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_dout_a", dout[0], 0);
        reset_n = 1'b1;

        // Fill/drain on the 8-deep standard FIFO.
        for (int k = 1; k <= 8; k++) begin
            set(0, 1'b1, 1'b0, 8'(k), 1'b0);
            tick();
        end
        chk("a_full8", ful[0], 1);
        chk("a_cnt8", cnt_a, 8);
        set(0, 1'b1, 1'b0, 8'h99, 1'b0);
        tick();
        chk("a_ovf9", ovf[0], 1);
        chk("a_cnt_hold", cnt_a, 8);
        for (int k = 1; k <= 8; k++) begin
            set(0, 1'b0, 1'b1, 8'h00, 1'b0);
            tick();
            chk("a_order", dout[0], k);
        end
        chk("a_empty", emp[0], 1);
        tick();
        chk("a_udf9", udf[0], 1);

        // FWFT visibility, then depth-5 wraparound.
        set(1, 1'b1, 1'b0, 8'h5A, 1'b0);
        tick();
        chk("b_fwft_vis", dout[1], 8'h5A);
        chk("b_fwft_ne", emp[1], 0);
        set(1, 1'b0, 1'b1, 8'h00, 1'b0);
        tick();
        chk("b_fwft_pop", emp[1], 1);
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                set(1, 1'b1, 1'b0, 8'(16 * r + k + 1), 1'b0);
                tick();
            end
            for (int k = 0; k < 4; k++) begin
                chk("b_wrap_head", dout[1], 16 * r + k + 1);
                set(1, 1'b0, 1'b1, 8'h00, 1'b0);
                tick();
            end
        end
        idle_all();

        // Simultaneous wr&rd at the full and empty boundaries.
        set(0, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        for (int k = 0; k < 8; k++) begin
            set(0, 1'b1, 1'b0, 8'($urandom), 1'b0);
            tick();
        end
        set(0, 1'b1, 1'b1, 8'hAA, 1'b0);
        tick();
        chk("a_full_wr_rd_cnt", cnt_a, 8);
        chk("a_full_wr_rd_ovf", ovf[0], 0);
        for (int k = 0; k < 8; k++) begin
            set(0, 1'b0, 1'b1, 8'h00, 1'b0);
            tick();
        end
        chk("a_aa_last", dout[0], 8'hAA);
        set(0, 1'b1, 1'b1, 8'h33, 1'b0);
        tick();
        chk("a_empty_wr_rd_cnt", cnt_a, 1);
        chk("a_empty_wr_rd_udf", udf[0], 1);
        chk("a_empty_wr_rd_dout", dout[0], 8'hAA);
        idle_all();

        // Thresholds on the 16-deep instance.
        for (int k = 1; k <= 16; k++) begin
            set(2, 1'b1, 1'b0, 8'(k), 1'b0);
            tick();
            if (k == 3)  chk("c_ae_at3", ae[2], 1);
            if (k == 4)  chk("c_ae_at4", ae[2], 0);
            if (k == 11) chk("c_af_at11", af[2], 0);
            if (k == 12) chk("c_af_at12", af[2], 1);
        end
        for (int k = 15; k >= 0; k--) begin
            set(2, 1'b0, 1'b1, 8'h00, 1'b0);
            tick();
            if (k == 11) chk("c_af_back", af[2], 0);
            if (k == 3)  chk("c_ae_back", ae[2], 1);
        end
        idle_all();

        // clear beats a same-cycle write.
        set(0, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        for (int k = 0; k < 9; k++) begin
            set(0, 1'b1, 1'b0, 8'($urandom), 1'b0);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            set(0, 1'b0, 1'b1, 8'h00, 1'b0);
            tick();
        end
        chk("a_pre_clr_cnt", cnt_a, 6);
        chk("a_pre_clr_ovf", ovf[0], 1);
        set(0, 1'b1, 1'b0, 8'h77, 1'b1);
        tick();
        chk("a_clr_cnt", cnt_a, 0);
        chk("a_clr_empty", emp[0], 1);
        chk("a_clr_ovf", ovf[0], 0);
        idle_all();

        // Random traffic with alternating fill/drain bias.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 3; i++) begin
                bit fill;
                fill = ((c / 150) % 2) == 0;
                set(i,
                    $urandom_range(0, 99) < (fill ? 70 : 30),
                    $urandom_range(0, 99) < (fill ? 30 : 70),
                    8'($urandom),
                    $urandom_range(0, 63) == 0);
            end
            tick();
        end

        // Asynchronous reset in the middle of a burst.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++)
                set(i, 1'b1, 1'b0, 8'($urandom), 1'b0);
            tick();
        end
        for (int i = 0; i < 3; i++)
            set(i, 1'b1, 1'b0, 8'($urandom), 1'b0);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_async_dout_a", dout[0], 0);
        chk("rst_async_cnt_c", cnt_c, 0);
        @(posedge clk);
        #1;
        check_all();
        reset_n = 1'b1;
        idle_all();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock, fully parametrised FIFO buffer, the next generation of the team's byte FIFO. Width and depth are generalised, and depth need not be a power of two. Adds occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. Used as the general-purpose elastic buffer between producer and consumer stages in the same clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 8, number of entries (>=2, any integer)
AW, $clog2(DEPTH), derived pointer width; not to be overridden
AFULL_TH, DEPTH-1, almost_full asserted when count >= AFULL_TH
AEMPTY_TH, 1, almost_empty asserted when count <= AEMPTY_TH
FWFT, 0, 0 = registered read (standard), 1 = first-word-fall-through

Ports:
clk  input  1  single clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
clear  input  1  synchronous flush, active high
wr  input  1  write request
data_in  input  WIDTH  write data
rd  input  1  read request (pop in FWFT mode)
data_out  output  WIDTH  read data
empty  output  1  no entries stored
full  output  1  DEPTH entries stored
almost_full  output  1  count >= AFULL_TH
almost_empty  output  1  count <= AEMPTY_TH
count  output  AW+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full and not accepted
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (reset_n low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=(AFULL_TH==0), overflow=0, underflow=0, data_out=0. Memory contents are not reset.
- Accept rules:
  - wr_ok = wr & (!full | rd_ok)
  - rd_ok = rd & !empty
  - Full with wr&rd: both accepted, count unchanged.
  - Empty with wr&rd: write only; rd is rejected and sets underflow.
- Pointers: increment on accept; wrap DEPTH-1 -> 0 explicitly (DEPTH need not be 2^n).
- count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither. All flags are registered from next-state count, so they are valid in the cycle after the edge that changes count.
- Standard mode (FWFT=0): data_out <= mem[rd_ptr] on the edge where rd_ok is set; valid from the following cycle; holds its last value otherwise (never zeroed).
- FWFT mode (FWFT=1): data_out = mem[rd_ptr] whenever empty=0; rd pops the head. Write-to-visible latency from empty is 1 cycle: the word is written at edge N, empty falls after N, and data_out is valid.
- A write into an empty FIFO followed by an immediate read is legal in both modes; there is no read-before-write hazard on the same address.
- overflow: set when wr & !wr_ok. underflow: set when rd & empty. Both hold until clear or reset.
- clear: highest priority over wr/rd in the same cycle. Sets pointers and count to 0, flags as in reset, and clears overflow/underflow. Memory and data_out are unchanged (in FWFT mode data_out is don't-care while empty).
- reset_n asserted mid-transfer: the in-flight write/read is discarded; state returns to reset values immediately.
- Illegal parameters (DEPTH<2, AFULL_TH>DEPTH, AEMPTY_TH>=DEPTH): elaboration-time assertion failure.

Decomposition:
- Shared package fifo_pkg:
  - clog2-style helper
  - pointer-wrap function next_ptr(ptr, depth)
  - enum fifo_mode_e {MODE_STD, MODE_FWFT}
- One sub-module, fifo_mem: WIDTH x DEPTH register array with one synchronous write port and one asynchronous read address. sync_fifo_param owns all pointer, count, flag and output-register logic.

Test Plan:
- Fill/drain, WIDTH=8, DEPTH=8, FWFT=0: write 0x01..0x08 -> full=1, count=8 after 8th edge; 9th write sets overflow=1, count stays 8. Read 8 -> data_out 0x01..0x08 in order, each 1 cycle after rd; empty=1; 9th rd sets underflow=1.
- Non-power-of-two wrap, DEPTH=5: 3 write/read rounds of 4 words (12 total, pointers wrap twice) -> output order exact, count never exceeds 5, full never set incorrectly.
- Simultaneous at boundaries: full + wr&rd with data 0xAA -> count stays 8, overflow stays 0, 0xAA read last. Empty + wr&rd -> count=1, underflow=1, data_out unchanged.
- Thresholds, DEPTH=16, AFULL_TH=12, AEMPTY_TH=3: almost_empty drops after 4th write; almost_full rises after 12th write; both toggle back on reads at 11 and 3.
- FWFT=1: write 0x5A into empty -> next cycle empty=0, data_out=0x5A without rd; rd -> empty=1 next cycle.
- clear and reset: with count=6 and overflow set, assert clear together with wr -> count=0, empty=1, overflow=0, write dropped. Drop reset_n mid-burst -> all outputs at reset values immediately, without waiting for a clock edge.
